// File: rtl/parametrised_writeback_arbiter_if.sv
// Bus between the execution lanes, the recovery logic and the register file
// write ports of the write-back arbiter.
interface parametrised_writeback_arbiter_if #(
   parameter int unsigned NUM_LANES    = 2,
   parameter int unsigned NUM_WR_PORTS = 1,
   parameter int unsigned BUF_DEPTH    = 4,
   parameter int unsigned PREG_WIDTH   = 7,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned AL_PTR_WIDTH = 6
);
   localparam int unsigned OCC_WIDTH = $clog2(NUM_LANES * BUF_DEPTH + 1);

   logic                                 clear;
   logic [NUM_LANES-1:0]                 inValid;
   logic [NUM_LANES*PREG_WIDTH-1:0]      inRegNum;
   logic [NUM_LANES*DATA_WIDTH-1:0]      inData;
   logic [NUM_LANES*AL_PTR_WIDTH-1:0]    inAlPtr;
   logic                                 inReady;
   logic                                 flushValid;
   logic [AL_PTR_WIDTH-1:0]              flushHeadPtr;
   logic [AL_PTR_WIDTH-1:0]              flushTailPtr;
   logic [NUM_WR_PORTS-1:0]              wrEn;
   logic [NUM_WR_PORTS*PREG_WIDTH-1:0]   wrRegNum;
   logic [NUM_WR_PORTS*DATA_WIDTH-1:0]   wrData;
   logic [OCC_WIDTH-1:0]                 occupancy;

   modport master (
      output clear, inValid, inRegNum, inData, inAlPtr,
      output flushValid, flushHeadPtr, flushTailPtr,
      input  inReady, wrEn, wrRegNum, wrData, occupancy
   );

   modport slave (
      input  clear, inValid, inRegNum, inData, inAlPtr,
      input  flushValid, flushHeadPtr, flushTailPtr,
      output inReady, wrEn, wrRegNum, wrData, occupancy
   );
endinterface

// File: rtl/parametrised_writeback_arbiter.sv
// Write-back arbiter: per-lane result FIFOs drained round-robin onto the
// register file write ports, with range-based squash and backpressure.
module parametrised_writeback_arbiter #(
   parameter int unsigned NUM_LANES    = 2,
   parameter int unsigned NUM_WR_PORTS = 1,
   parameter int unsigned BUF_DEPTH    = 4,
   parameter int unsigned PREG_WIDTH   = 7,
   parameter int unsigned DATA_WIDTH   = 32,
   parameter int unsigned AL_PTR_WIDTH = 6
) (
   input logic clk,
   input logic rst_n,
   parametrised_writeback_arbiter_if.slave wb
);
   localparam int unsigned PTR_W      = $clog2(BUF_DEPTH);
   localparam int unsigned CNT_W      = $clog2(BUF_DEPTH + 1);
   localparam int unsigned LANE_W     = (NUM_LANES > 1) ? $clog2(NUM_LANES) : 1;
   localparam int unsigned OCC_W      = $clog2(NUM_LANES * BUF_DEPTH + 1);
   localparam int unsigned PORT_CNT_W = $clog2(NUM_WR_PORTS + 1);

   typedef struct packed {
      logic                    live;
      logic [AL_PTR_WIDTH-1:0] al_ptr;
      logic [PREG_WIDTH-1:0]   reg_num;
      logic [DATA_WIDTH-1:0]   data;
   } entry_t;

   entry_t                 mem     [NUM_LANES][BUF_DEPTH];
   logic [PTR_W-1:0]       rd_ptr  [NUM_LANES];
   logic [PTR_W-1:0]       wr_ptr  [NUM_LANES];
   logic [CNT_W-1:0]       count   [NUM_LANES];
   logic [LANE_W-1:0]      rr_ptr;
   logic [OCC_W-1:0]       occ_q;
   logic [NUM_WR_PORTS-1:0]                 wr_en_q;
   logic [NUM_WR_PORTS-1:0][PREG_WIDTH-1:0] wr_reg_q;
   logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] wr_data_q;

   logic [NUM_LANES-1:0][PREG_WIDTH-1:0]    in_reg;
   logic [NUM_LANES-1:0][DATA_WIDTH-1:0]    in_data;
   logic [NUM_LANES-1:0][AL_PTR_WIDTH-1:0]  in_al;

   entry_t                 head      [NUM_LANES];
   logic                   in_ready_c;
   logic [NUM_LANES-1:0]   head_ok;
   logic [NUM_LANES-1:0]   pop_dead;
   logic [NUM_LANES-1:0]   enq;
   logic [NUM_LANES-1:0]   grant;
   logic [NUM_LANES-1:0]   pop;
   logic [NUM_LANES-1:0][BUF_DEPTH-1:0] in_buf;
   logic [NUM_LANES-1:0][BUF_DEPTH-1:0] hit_mask;
   logic [LANE_W-1:0]      scan_lane [NUM_LANES];
   logic [LANE_W-1:0]      rr_d;
   logic [PORT_CNT_W-1:0]  ngrant;
   logic [OCC_W-1:0]       occ_d;
   logic [NUM_WR_PORTS-1:0]                 wr_en_d;
   logic [NUM_WR_PORTS-1:0][PREG_WIDTH-1:0] reg_d;
   logic [NUM_WR_PORTS-1:0][DATA_WIDTH-1:0] data_d;

   assign in_reg  = wb.inRegNum;
   assign in_data = wb.inData;
   assign in_al   = wb.inAlPtr;

   // Flush range membership; a wrapped range covers the top and bottom of the pointer space.
   function automatic logic flush_hit(input logic valid,
                                      input logic [AL_PTR_WIDTH-1:0] hd,
                                      input logic [AL_PTR_WIDTH-1:0] tl,
                                      input logic [AL_PTR_WIDTH-1:0] p);
      if (hd <= tl) return valid && (p >= hd) && (p < tl);
      return valid && ((p >= hd) || (p < tl));
   endfunction

   // Per-lane head status, squash mask and enqueue decision
   always_comb begin : lane_status
      in_ready_c = 1'b1;
      head_ok    = '0;
      pop_dead   = '0;
      in_buf     = '0;
      hit_mask   = '0;
      enq        = '0;
      for (int i = 0; i < NUM_LANES; i++) begin
         head[i] = mem[i][rd_ptr[i]];
         if (count[i] == CNT_W'(BUF_DEPTH)) in_ready_c = 1'b0;
         head_ok[i]  = (count[i] != '0) && head[i].live &&
                       !flush_hit(wb.flushValid, wb.flushHeadPtr, wb.flushTailPtr, head[i].al_ptr);
         pop_dead[i] = (count[i] != '0) && !head[i].live;
         for (int j = 0; j < BUF_DEPTH; j++) begin
            in_buf[i][j]   = CNT_W'(PTR_W'(PTR_W'(j) - rd_ptr[i])) < count[i];
            hit_mask[i][j] = in_buf[i][j] && mem[i][j].live &&
                             flush_hit(wb.flushValid, wb.flushHeadPtr, wb.flushTailPtr, mem[i][j].al_ptr);
         end
      end
      for (int i = 0; i < NUM_LANES; i++) begin
         enq[i] = wb.inValid[i] && in_ready_c && !wb.clear &&
                  !flush_hit(wb.flushValid, wb.flushHeadPtr, wb.flushTailPtr, in_al[i]);
      end
   end

   // Round-robin scan from rr_ptr; k-th grant lands on port k so enables pack low
   always_comb begin : grant_scan
      grant   = '0;
      wr_en_d = '0;
      reg_d   = '0;
      data_d  = '0;
      rr_d    = rr_ptr;
      ngrant  = '0;
      for (int o = 0; o < NUM_LANES; o++) begin
         scan_lane[o] = LANE_W'((32'(rr_ptr) + 32'(o)) % NUM_LANES);
         if (head_ok[scan_lane[o]] && (ngrant < PORT_CNT_W'(NUM_WR_PORTS))) begin
            grant[scan_lane[o]] = 1'b1;
            for (int p = 0; p < NUM_WR_PORTS; p++) begin
               if (ngrant == PORT_CNT_W'(p)) begin
                  wr_en_d[p] = 1'b1;
                  reg_d[p]   = head[scan_lane[o]].reg_num;
                  data_d[p]  = head[scan_lane[o]].data;
               end
            end
            rr_d   = LANE_W'((32'(scan_lane[o]) + 32'd1) % NUM_LANES);
            ngrant = ngrant + PORT_CNT_W'(1);
         end
      end
   end

   // Live count after the edge: new entries in, granted and squashed entries out
   always_comb begin : occ_next
      pop   = grant | pop_dead;
      occ_d = occ_q;
      for (int i = 0; i < NUM_LANES; i++) begin
         occ_d = occ_d + OCC_W'(enq[i]) - OCC_W'(grant[i]);
         for (int j = 0; j < BUF_DEPTH; j++) begin
            occ_d = occ_d - OCC_W'(hit_mask[i][j]);
         end
      end
   end

   // FIFO storage: no reset needed, validity comes from the counts
   always_ff @(posedge clk) begin : fifo_mem
      for (int i = 0; i < NUM_LANES; i++) begin
         for (int j = 0; j < BUF_DEPTH; j++) begin
            if (hit_mask[i][j]) mem[i][j].live <= 1'b0;
         end
         if (enq[i]) mem[i][wr_ptr[i]] <= '{live: 1'b1, al_ptr: in_al[i],
                                            reg_num: in_reg[i], data: in_data[i]};
      end
   end

   // FIFO control, round-robin pointer and registered write ports
   always_ff @(posedge clk or negedge rst_n) begin : ctrl_regs
      if (!rst_n) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         rr_ptr    <= '0;
         occ_q     <= '0;
         wr_en_q   <= '0;
         wr_reg_q  <= '0;
         wr_data_q <= '0;
      end else if (wb.clear) begin
         for (int i = 0; i < NUM_LANES; i++) begin
            rd_ptr[i] <= '0;
            wr_ptr[i] <= '0;
            count[i]  <= '0;
         end
         occ_q   <= '0;
         wr_en_q <= '0;
      end else begin
         for (int i = 0; i < NUM_LANES; i++) begin
            if (enq[i]) wr_ptr[i] <= wr_ptr[i] + PTR_W'(1);
            if (pop[i]) rd_ptr[i] <= rd_ptr[i] + PTR_W'(1);
            count[i] <= count[i] + CNT_W'(enq[i]) - CNT_W'(pop[i]);
         end
         rr_ptr    <= rr_d;
         occ_q     <= occ_d;
         wr_en_q   <= wr_en_d;
         wr_reg_q  <= reg_d;
         wr_data_q <= data_d;
      end
   end

   assign wb.inReady   = in_ready_c;
   assign wb.wrEn      = wr_en_q;
   assign wb.wrRegNum  = wr_reg_q;
   assign wb.wrData    = wr_data_q;
   assign wb.occupancy = occ_q;
endmodule
